// File: rtl/sonar_trig_ctrl.sv
// Ultrasonic ranging initiator: trigger pulse, echo wait with timeout, echo-width timing
// in distance ticks, and an 8-bit distance published with one-cycle Valid/Err strobes.
module sonar_trig_ctrl #(
    parameter int TrigCycles = 500,
    parameter int TickDiv    = 2900,
    parameter int WaitMax    = 1500000,
    parameter int HoldCycles = 3000000,
    parameter int Auto       = 0
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       Start,
    input  logic       Echo,
    output logic       Trig,
    output logic [7:0] Dist,
    output logic       Valid,
    output logic       Err,
    output logic       Busy
);

    localparam int TIMER_MAX = (TrigCycles > WaitMax)
                             ? ((TrigCycles > HoldCycles) ? TrigCycles : HoldCycles)
                             : ((WaitMax > HoldCycles) ? WaitMax : HoldCycles);
    localparam int TIMER_W = $clog2(TIMER_MAX + 1);
    localparam int TICK_W  = $clog2(TickDiv + 1);

    localparam logic [TIMER_W-1:0] TRIG_LAST = TIMER_W'(TrigCycles - 1);
    localparam logic [TIMER_W-1:0] WAIT_LAST = TIMER_W'(WaitMax - 1);
    localparam logic [TIMER_W-1:0] HOLD_LAST = TIMER_W'(HoldCycles - 1);
    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TickDiv - 1);
    localparam bit                 AUTO_EN   = (Auto != 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_ECHO,
        S_MEASURE,
        S_HOLDOFF
    } state_t;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [7:0]           dcnt_q, dcnt_d;
    logic [7:0]           dist_q, dist_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;

    logic                 echo_meta_q, echo_s_q, echo_dly_q;
    logic                 echo_rise, echo_fall;
    logic                 tick_wrap;

    // Two-flop synchronizer plus one delay flop for edge detection
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            echo_dly_q  <= 1'b0;
        end else begin
            echo_meta_q <= Echo;
            echo_s_q    <= echo_meta_q;
            echo_dly_q  <= echo_s_q;
        end
    end

    assign echo_rise = echo_s_q & ~echo_dly_q;
    assign echo_fall = ~echo_s_q & echo_dly_q;
    assign tick_wrap = (tick_q == TICK_LAST);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            tick_q  <= '0;
            dcnt_q  <= '0;
            dist_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            tick_q  <= tick_d;
            dcnt_q  <= dcnt_d;
            dist_q  <= dist_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        tick_d  = tick_q;
        dcnt_d  = dcnt_q;
        dist_d  = dist_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Start || AUTO_EN) begin
                    state_d = S_TRIG;
                    timer_d = '0;
                end
            end
            S_TRIG: begin
                if (timer_q == TRIG_LAST) begin
                    state_d = S_WAIT_ECHO;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_ECHO: begin
                if (echo_rise) begin
                    state_d = S_MEASURE;
                    tick_d  = '0;
                    dcnt_d  = '0;
                end else if (timer_q == WAIT_LAST) begin
                    state_d = S_HOLDOFF;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_MEASURE: begin
                // The falling-edge cycle still counts as an echo-high cycle, so a wrap
                // there contributes to the result (and can itself overrange).
                if (tick_wrap && (dcnt_q == 8'hFF)) begin
                    state_d = S_HOLDOFF;
                    timer_d = '0;
                    err_d   = 1'b1;
                end else if (echo_fall) begin
                    state_d = S_HOLDOFF;
                    timer_d = '0;
                    dist_d  = dcnt_q + {7'd0, tick_wrap};
                    valid_d = 1'b1;
                end else if (tick_wrap) begin
                    tick_d = '0;
                    dcnt_d = dcnt_q + 8'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            S_HOLDOFF: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        Trig = (state_q == S_TRIG);
        Busy = (state_q != S_IDLE);
    end

    assign Dist  = dist_q;
    assign Valid = valid_q;
    assign Err   = err_q;

endmodule

// File: tb/tb_sonar_trig_ctrl.sv
// Self-checking bench for sonar_trig_ctrl: scenario tasks against a timing/result model
// derived from echo width, echo delay and the configured cycle counts.
module tb_sonar_trig_ctrl;

    localparam int TRIG_C = 4;
    localparam int TICK   = 10;
    localparam int WAIT_M = 100;
    localparam int HOLD   = 20;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic       Start, Echo;
    logic       Trig, Valid, Err, Busy;
    logic [7:0] Dist;
    logic       Start_a, Echo_a;
    logic       Trig_a, Valid_a, Err_a, Busy_a;
    logic [7:0] Dist_a;

    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_dist = 8'd0;

    always #5 Clk = ~Clk;

    sonar_trig_ctrl #(
        .TrigCycles(TRIG_C), .TickDiv(TICK), .WaitMax(WAIT_M), .HoldCycles(HOLD), .Auto(0)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Echo(Echo),
        .Trig(Trig), .Dist(Dist), .Valid(Valid), .Err(Err), .Busy(Busy)
    );

    sonar_trig_ctrl #(
        .TrigCycles(TRIG_C), .TickDiv(TICK), .WaitMax(WAIT_M), .HoldCycles(HOLD), .Auto(1)
    ) dut_a (
        .Clk(Clk), .Rst_n(Rst_n), .Start(Start_a), .Echo(Echo_a),
        .Trig(Trig_a), .Dist(Dist_a), .Valid(Valid_a), .Err(Err_a), .Busy(Busy_a)
    );

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        int bad;
        Rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if (Trig !== 1'b0 || Valid !== 1'b0 || Err !== 1'b0 || Busy !== 1'b0 || Dist !== 8'd0
            || Busy_a !== 1'b0 || Trig_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got trig=%b valid=%b err=%b busy=%b dist=%0d busy_a=%b expected all 0",
                     Trig, Valid, Err, Busy, Dist, Busy_a);
        end
        Rst_n = 1'b1;
        bad = 0;
        repeat (50) begin
            step();
            if (Trig !== 1'b0 || Busy !== 1'b0 || Valid !== 1'b0 || Err !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_quiet: got %0d active cycles expected 0", bad);
        end
        $display("reset: done, idle 50 cycles");
    endtask

    // One full measure cycle. width==0 means the echo never arrives.
    task automatic run_measure(input string name, input int delay, input int width, input bit noise);
        int         trig_len, strobe_off, hold_len, exp_off, t, busy_bad;
        bit         exp_err;
        logic [7:0] exp_dist;

        if (width == 0) begin
            exp_err = 1'b1;
            exp_off = WAIT_M;
        end else if (width >= TICK * 256) begin
            exp_err = 1'b1;
            exp_off = delay + 3 + TICK * 256;
        end else begin
            exp_err = 1'b0;
            exp_off = delay + width + 3;
        end
        exp_dist = exp_err ? last_dist : 8'(width / TICK);

        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++;
        if (Trig !== 1'b1 || Busy !== 1'b1) begin
            errors++;
            $display("FAIL %s trig_start: got trig=%b busy=%b expected 1 1", name, Trig, Busy);
        end
        trig_len = 0;
        while (Trig === 1'b1 && trig_len < 50) begin
            trig_len++;
            step();
        end
        checks++;
        if (trig_len != TRIG_C) begin
            errors++;
            $display("FAIL %s trig_len: got %0d expected %0d", name, trig_len, TRIG_C);
        end

        strobe_off = -1;
        t = 0;
        while (t < 3000 && strobe_off < 0) begin
            Echo = (width > 0) && (t >= delay) && (t < delay + width);
            if (noise) Start = 1'($urandom_range(0, 1));
            step();
            t++;
            if (Valid === 1'b1 || Err === 1'b1) strobe_off = t;
        end
        checks++;
        if (strobe_off != exp_off) begin
            errors++;
            $display("FAIL %s strobe_time: got %0d expected %0d", name, strobe_off, exp_off);
        end
        checks++;
        if (Valid !== !exp_err || Err !== exp_err) begin
            errors++;
            $display("FAIL %s strobe_kind: got valid=%b err=%b expected valid=%b err=%b",
                     name, Valid, Err, !exp_err, exp_err);
        end
        checks++;
        if (Dist !== exp_dist) begin
            errors++;
            $display("FAIL %s dist: got %0d expected %0d", name, Dist, exp_dist);
        end
        last_dist = exp_dist;

        hold_len = 0;
        while (Busy === 1'b1 && hold_len < 100) begin
            Echo = (width > 0) && (t >= delay) && (t < delay + width);
            if (noise) Start = 1'($urandom_range(0, 1));
            step();
            t++;
            hold_len++;
            if (hold_len == 1) begin
                checks++;
                if (Valid !== 1'b0 || Err !== 1'b0) begin
                    errors++;
                    $display("FAIL %s strobe_width: got valid=%b err=%b expected 0 0", name, Valid, Err);
                end
            end
        end
        Start = 1'b0;
        Echo  = 1'b0;
        checks++;
        if (hold_len != HOLD) begin
            errors++;
            $display("FAIL %s holdoff: got %0d expected %0d", name, hold_len, HOLD);
        end
        busy_bad = 0;
        repeat (8) begin
            step();
            if (Busy !== 1'b0 || Trig !== 1'b0) busy_bad++;
        end
        checks++;
        if (busy_bad != 0) begin
            errors++;
            $display("FAIL %s stays_idle: got %0d busy cycles expected 0", name, busy_bad);
        end
        $display("%s: delay=%0d width=%0d strobe@%0d dist=%0d err=%b",
                 name, delay, width, strobe_off, Dist, exp_err);
    endtask

    task automatic test_nominal();
        run_measure("nominal", 10, 57, 1'b0);
    endtask

    task automatic test_timeout();
        run_measure("timeout", 0, 0, 1'b0);
    endtask

    task automatic test_overrange();
        run_measure("overrange", 5, 2600, 1'b0);
    endtask

    task automatic test_boundary();
        run_measure("boundary_max", 3, 2559, 1'b0);
        run_measure("boundary_min", 7, 9, 1'b0);
    endtask

    task automatic test_random();
        int d, w;
        for (int i = 0; i < 6; i++) begin
            d = $urandom_range(0, 90);
            w = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : $urandom_range(1, 2559);
            run_measure("random", d, w, 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        run_measure("start_ignored", $urandom_range(0, 90), $urandom_range(1, 300), 1'b1);
        run_measure("start_ignored_to", 0, 0, 1'b1);
    endtask

    task automatic test_reset_in_measure();
        int n, bad;
        Start = 1'b1;
        step();
        Start = 1'b0;
        n = 0;
        while (Trig === 1'b1 && n < 50) begin
            n++;
            step();
        end
        Echo = 1'b1;
        repeat (30) step();
        #2;
        Rst_n = 1'b0;
        #1;
        checks++;
        if (Trig !== 1'b0 || Busy !== 1'b0 || Valid !== 1'b0 || Err !== 1'b0 || Dist !== 8'd0) begin
            errors++;
            $display("FAIL reset_measure_abort: got trig=%b busy=%b valid=%b err=%b dist=%0d expected 0 0 0 0 0",
                     Trig, Busy, Valid, Err, Dist);
        end
        last_dist = 8'd0;
        repeat (3) step();
        Echo  = 1'b0;
        Rst_n = 1'b1;
        bad = 0;
        repeat (30) begin
            step();
            if (Valid !== 1'b0 || Err !== 1'b0 || Busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL reset_measure_quiet: got %0d active cycles expected 0", bad);
        end
        $display("reset_in_measure: aborted after 30 echo cycles");
    endtask

    task automatic test_auto();
        int n, hold, off;
        Echo_a = 1'b0;
        n = 0;
        while (Err_a !== 1'b1 && n < 400) begin
            step();
            n++;
        end
        checks++;
        if (Err_a !== 1'b1) begin
            errors++;
            $display("FAIL auto_timeout: got err_a=%b expected 1", Err_a);
        end
        hold = 0;
        while (Busy_a === 1'b1 && hold < 100) begin
            step();
            hold++;
        end
        checks++;
        if (hold != HOLD) begin
            errors++;
            $display("FAIL auto_holdoff: got %0d expected %0d", hold, HOLD);
        end
        step();
        checks++;
        if (Busy_a !== 1'b1 || Trig_a !== 1'b1) begin
            errors++;
            $display("FAIL auto_retrigger: got busy_a=%b trig_a=%b expected 1 1", Busy_a, Trig_a);
        end
        n = 0;
        while (Trig_a === 1'b1 && n < 50) begin
            step();
            n++;
        end
        off = -1;
        for (int t = 0; t < 200 && off < 0; t++) begin
            Echo_a = (t < 35);
            step();
            if (Valid_a === 1'b1 || Err_a === 1'b1) off = t + 1;
        end
        Echo_a = 1'b0;
        checks++;
        if (off != 38 || Valid_a !== 1'b1 || Dist_a !== 8'd3) begin
            errors++;
            $display("FAIL auto_measure: got off=%0d valid_a=%b dist_a=%0d expected 38 1 3",
                     off, Valid_a, Dist_a);
        end
        $display("auto: retrigger after holdoff, measured dist=%0d", Dist_a);
    endtask

    initial begin
        Rst_n   = 1'b0;
        Start   = 1'b0;
        Echo    = 1'b0;
        Start_a = 1'b0;
        Echo_a  = 1'b0;
        test_reset();
        test_nominal();
        test_timeout();
        test_overrange();
        test_boundary();
        test_random();
        test_start_ignored();
        test_reset_in_measure();
        test_auto();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sonar_trig_ctrl.md
# sonar_trig_ctrl

Initiator side of the ultrasonic ranging interface: generates the sensor trigger pulse, waits for the echo, times the echo width in distance ticks and publishes an 8-bit distance with a one-cycle valid strobe. Sits between the top-level sequencing logic and the sensor pins. It replaces the free-running gate/count path with a controlled measure cycle that includes timeout and error reporting. Dist feeds the existing comparator, decimal splitter and 7-segment display chain unchanged.

## Interface

- TrigCycles, 500: Trig high time in Clk cycles (10 µs @ 50 MHz).
- TickDiv, 2900: Clk cycles per distance unit (58 µs/cm @ 50 MHz).
- WaitMax, 1500000: max cycles in WAIT_ECHO before timeout.
- HoldCycles, 3000000: dead time after each measurement, in Clk cycles.
- Auto, 0: 1 = re-trigger automatically after holdoff; 0 = wait for Start.
- Clk  input  1  system clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start  input  1  request one measurement; sampled only in IDLE.
- Echo  input  1  sensor echo, asynchronous to Clk.
- Trig  output  1  sensor trigger pulse.
- Dist  output  8  last valid distance, unsigned.
- Valid  output  1  one-cycle strobe, Dist updated this cycle.
- Err  output  1  one-cycle strobe, timeout or overrange.
- Busy  output  1  high in every state except IDLE.

## Operation

- Echo passes through a 2-flop synchronizer (echo_s); a third flop echo_d is used for edge detection. Rise = echo_s & ~echo_d; fall = ~echo_s & echo_d.
- IDLE: Trig=0, Busy=0. Go to TRIG on Start=1 or Auto=1.
- TRIG: Trig=1 for exactly TrigCycles cycles, then WAIT_ECHO.
- WAIT_ECHO: the wait counter increments each cycle.
  - On rise: go to MEASURE; clear the tick and distance counters.
  - If the counter reaches WaitMax with no rise: pulse Err, leave Dist unchanged, go to HOLDOFF.
  - An echo already high on entry is not a rise; the block waits for it to go low and then rise.
- MEASURE: the tick counter counts 0..TickDiv-1. Each wrap increments the 8-bit distance counter.
  - On fall: Dist <= distance counter, pulse Valid, go to HOLDOFF.
  - If a wrap occurs while the distance counter = 255: overrange. Pulse Err, leave Dist unchanged, go to HOLDOFF.
- HOLDOFF: count HoldCycles, then go to IDLE.
  - With Auto=1, the next cycle leaves IDLE immediately.
- Start outside IDLE is ignored; it is not queued.
- Result: Dist = floor(H / TickDiv), where H = synchronized echo-high cycles. 255 is a legal value.
- Valid and Err are never asserted in the same cycle.

## Timing

- Reset (async, Rst_n=0): state IDLE, Trig=0, Dist=0, Valid=0, Err=0, Busy=0, all counters 0, sync flops 0. Reset mid-operation aborts immediately with no strobe.
- Start high at edge k: TRIG entered at edge k; Trig and Busy high from k through k+TrigCycles-1; Trig low at k+TrigCycles.
- Echo latency: a pad transition is detected on the 3rd Clk edge after it (2 sync flops + edge flop).
- Valid/Err: registered, asserted in the cycle after detection, high for exactly 1 cycle.
- Busy drops on the first cycle back in IDLE.

## Test plan

Bench parameters: TrigCycles=4, TickDiv=10, WaitMax=100, HoldCycles=20, Auto=0.

- Reset then idle: Rst_n low 3 cycles, then high. Required: all outputs 0; Start=0 for 50 cycles keeps Trig=0 and Busy=0.
- Nominal: Start pulse, Echo rises 10 cycles after Trig falls, Echo high 57 cycles. Required: Trig high exactly 4 cycles; Dist=5 with one Valid pulse; Busy low 20 cycles after the pulse.
- Timeout: Start, Echo held low. Required: Err pulse 100 cycles into WAIT_ECHO; Dist keeps its previous value; no Valid.
- Overrange: Start, Echo high 2600 cycles. Required: Err at the 256th tick wrap; Dist unchanged.
- Boundary: Echo high 2559 cycles. Required: Dist=255 with Valid. Echo high 9 cycles: Dist=0 with Valid.
- Start ignored while Busy; Auto=1 re-triggers immediately after HOLDOFF; Rst_n asserted in MEASURE: Trig=0 and Busy=0 at once, with no Valid or Err.
